// File: rtl/rotation_pkg.sv
// Shared AHB constants for the rotation DMA memory responder.
// Holds transfer/size/burst codes and the arbiter state encoding.
package rotation_pkg;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_GRANT
  } arb_state_e;

  // NONSEQ and SEQ are the only codes that start a data phase.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_arb_single.sv
// Single-master AHB arbiter: grants the bus P_GRANT_DLY cycles after the
// request is first sampled, and holds the grant until the master is idle.
module ahb_arb_single
  import rotation_pkg::*;
#(
  parameter int P_GRANT_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hbusreq_i,
  input  logic [1:0] htrans_i,
  input  logic       hready_i,
  output logic       hgrant_o
);

  localparam int CW = (P_GRANT_DLY > 1) ? $clog2(P_GRANT_DLY) : 1;

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter holds the remaining wait cycles minus one, so a request seen
  // at edge t produces a grant visible in cycle t+1+P_GRANT_DLY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (hbusreq_i) begin
          if (P_GRANT_DLY == 0) begin
            state_d = ARB_GRANT;
          end else begin
            state_d = ARB_WAIT;
            cnt_d   = CW'(P_GRANT_DLY - 1);
          end
        end
      end
      ARB_WAIT: begin
        if (!hbusreq_i) begin
          state_d = ARB_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ARB_GRANT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ARB_GRANT: begin
        if (!hbusreq_i && (htrans_i == TR_IDLE) && hready_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hgrant_o = (state_q == ARB_GRANT);

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB slave word memory with single-master arbiter, read forwarding and debug port.
// Optional wait-state insertion on O_DMA_HREADY is enabled by `AHB_WAIT_STATE_EN.
module ahb_mem_responder
  import rotation_pkg::*;
#(
  parameter  int P_DEPTH     = 1024,
  parameter  int P_GRANT_DLY = 2,
  parameter  int P_WAIT      = 1,
  localparam int AW          = $clog2(P_DEPTH)
) (
  input  logic          I_HCLK,
  input  logic          I_HRESET_N,
  input  logic          I_DMA_HBUSREQ,
  output logic          O_DMA_HGRANT,
  input  logic [31:0]   I_DMA_HADDR,
  input  logic [1:0]    I_DMA_HTRANS,
  input  logic          I_DMA_HWRITE,
  input  logic [2:0]    I_DMA_HSIZE,
  input  logic [2:0]    I_DMA_HBURST,
  input  logic [31:0]   I_DMA_HWDATA,
  output logic [31:0]   O_DMA_HRDATA,
  output logic          O_DMA_HREADY,
  input  logic [AW-1:0] I_DBG_ADDR,
  output logic [31:0]   O_DBG_RDATA
);

  logic          hgrant;
  logic          hready;
  logic          dp_v_q, dp_v_d;
  logic          dp_write_q, dp_write_d;
  logic [AW-1:0] dp_idx_q, dp_idx_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic [31:0]   mem_q [P_DEPTH];
  logic [AW-1:0] addr_idx;
  logic          accept;
  logic          wr_commit;
  logic          fwd_hit;
  logic          unused_inputs;

  ahb_arb_single #(
    .P_GRANT_DLY(P_GRANT_DLY)
  ) u_arb (
    .clk      (I_HCLK),
    .rst_n    (I_HRESET_N),
    .hbusreq_i(I_DMA_HBUSREQ),
    .htrans_i (I_DMA_HTRANS),
    .hready_i (hready),
    .hgrant_o (hgrant)
  );

  // Upper address bits are dropped, so out-of-range addresses alias modulo depth.
  assign addr_idx  = I_DMA_HADDR[AW+1:2];
  assign accept    = hready & hgrant & is_active_trans(I_DMA_HTRANS);
  assign wr_commit = dp_v_q & dp_write_q & hready & I_HRESET_N;
  assign fwd_hit   = wr_commit & (dp_idx_q == addr_idx);

  always_comb begin
    dp_v_d     = dp_v_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    hrdata_d   = hrdata_q;
    if (hready) begin
      dp_v_d = accept;
      if (accept) begin
        dp_write_d = I_DMA_HWRITE;
        dp_idx_d   = addr_idx;
        if (!I_DMA_HWRITE) begin
          hrdata_d = fwd_hit ? I_DMA_HWDATA : mem_q[addr_idx];
        end
      end
    end
  end

  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      dp_v_q     <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      hrdata_q   <= '0;
    end else begin
      dp_v_q     <= dp_v_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      hrdata_q   <= hrdata_d;
    end
  end

  // Memory is deliberately not reset; contents survive I_HRESET_N.
  always_ff @(posedge I_HCLK) begin
    if (wr_commit) begin
      mem_q[dp_idx_q] <= I_DMA_HWDATA;
    end
  end

`ifdef AHB_WAIT_STATE_EN
  localparam int WCW = (P_WAIT > 1) ? $clog2(P_WAIT) : 1;

  logic           hready_q, hready_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  always_comb begin
    hready_d = hready_q;
    wcnt_d   = wcnt_q;
    if (!hready_q) begin
      if (wcnt_q == '0) begin
        hready_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q - WCW'(1);
      end
    end else if (accept && (P_WAIT > 0)) begin
      hready_d = 1'b0;
      wcnt_d   = WCW'(P_WAIT - 1);
    end
  end

  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      hready_q <= 1'b1;
      wcnt_q   <= '0;
    end else begin
      hready_q <= hready_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign hready        = hready_q;
  assign unused_inputs = ^{I_DMA_HADDR[31:AW+2], I_DMA_HADDR[1:0],
                           I_DMA_HSIZE != HSIZE_WORD, I_DMA_HBURST};
`else
  assign hready        = 1'b1;
  assign unused_inputs = ^{I_DMA_HADDR[31:AW+2], I_DMA_HADDR[1:0],
                           I_DMA_HSIZE != HSIZE_WORD, I_DMA_HBURST, P_WAIT != 0};
`endif

  assign O_DMA_HGRANT = hgrant;
  assign O_DMA_HREADY = hready;
  assign O_DMA_HRDATA = hrdata_q;
  assign O_DBG_RDATA  = mem_q[I_DBG_ADDR];

endmodule

// File: tb/tb_ahb_mem_responder.sv
// Self-checking bench for ahb_mem_responder: directed scenarios plus randomized
// AHB traffic compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_ahb_mem_responder;
  import rotation_pkg::*;

  localparam int DEPTH     = 1024;
  localparam int AW        = 10;
  localparam int GRANT_DLY = 2;
  localparam int WAIT_P    = 2;
`ifdef AHB_WAIT_STATE_EN
  localparam int WAITS = WAIT_P;
`else
  localparam int WAITS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hbusreq;
  logic          hgrant;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [31:0]   hwdata;
  logic [31:0]   hrdata;
  logic          hready;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_rdata;

  int          check_count = 0;
  int          pass_count  = 0;
  int          cyc         = 0;
  logic [31:0] next_wdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ahb_mem_responder #(
    .P_DEPTH    (DEPTH),
    .P_GRANT_DLY(GRANT_DLY),
    .P_WAIT     (WAIT_P)
  ) dut (
    .I_HCLK       (clk),
    .I_HRESET_N   (rst_n),
    .I_DMA_HBUSREQ(hbusreq),
    .O_DMA_HGRANT (hgrant),
    .I_DMA_HADDR  (haddr),
    .I_DMA_HTRANS (htrans),
    .I_DMA_HWRITE (hwrite),
    .I_DMA_HSIZE  (hsize),
    .I_DMA_HBURST (hburst),
    .I_DMA_HWDATA (hwdata),
    .O_DMA_HRDATA (hrdata),
    .O_DMA_HREADY (hready),
    .I_DBG_ADDR   (dbg_addr),
    .O_DBG_RDATA  (dbg_rdata)
  );

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, actual, expected, $time);
  endfunction

  function automatic void checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'd0, actual}, {31'd0, expected});
  endfunction

  // Transaction-level model: ordered AHB transfers against a word array.
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_valid = 1'b0;
  bit          m_grant, m_pend, m_pend_wr, m_rdata_known;
  int          m_run, m_wait, m_pidx;
  logic [31:0] m_rdata;

  // Advances the model by one rising edge using the inputs that edge will sample.
  function automatic void modelStep();
    bit ready;
    bit acc;
    if (!rst_n) begin
      m_valid = 1'b1; m_grant = 1'b0; m_run = 0; m_wait = 0;
      m_rdata = 32'd0; m_rdata_known = 1'b1; m_pend = 1'b0;
    end else if (m_valid) begin
      ready = (m_wait == 0);
      acc   = ready && m_grant && (htrans == TR_NONSEQ || htrans == TR_SEQ);
      if (m_pend && ready) begin
        if (m_pend_wr) begin
          m_mem[m_pidx]   = hwdata;
          m_known[m_pidx] = 1'b1;
        end
        m_pend = 1'b0;
      end
      if (acc) begin
        m_pend    = 1'b1;
        m_pend_wr = hwrite;
        m_pidx    = int'({2'b00, haddr[31:2]} % DEPTH);
        if (!hwrite) begin
          m_rdata       = m_mem[m_pidx];
          m_rdata_known = m_known[m_pidx];
        end
        m_wait = WAITS;
      end else if (m_wait > 0) begin
        m_wait--;
      end
      if (m_grant) begin
        if (!hbusreq && htrans == TR_IDLE && ready) m_grant = 1'b0;
        m_run = 0;
      end else if (hbusreq) begin
        m_run++;
        if (m_run > GRANT_DLY) m_grant = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      checkBit("hgrant", hgrant, m_grant);
      checkBit("hready", hready, m_wait == 0);
      if (m_rdata_known) checkOutput("hrdata", hrdata, m_rdata);
      if (m_known[dbg_addr]) checkOutput("dbg_rdata", dbg_rdata, m_mem[dbg_addr]);
    end
    modelStep();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic requestBus();
    hbusreq = 1'b1;
    for (int g = 0; g < 32 && !hgrant; g++) tick();
    checkBit("grant_wait", hgrant, 1'b1);
  endtask

  task automatic releaseBus();
    hbusreq = 1'b0;
    htrans  = TR_IDLE;
    for (int g = 0; g < 32 && hgrant; g++) tick();
    checkBit("grant_release", hgrant, 1'b0);
  endtask

  // Drives one address phase; HWDATA carries the previous beat's data meanwhile.
  task automatic addrPhase(input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic seq);
    bit rdy;
    htrans = seq ? TR_SEQ : TR_NONSEQ;
    haddr  = addr;
    hwrite = wr;
    hwdata = next_wdata;
    rdy    = 1'b0;
    for (int g = 0; g < 64 && !rdy; g++) begin
      @(negedge clk);
      rdy = hready && hgrant;
      @(posedge clk);
      #1;
    end
    checkBit("accept_in_budget", rdy, 1'b1);
    next_wdata = wdata;
  endtask

  task automatic endStream();
    bit rdy;
    htrans = TR_IDLE;
    hwdata = next_wdata;
    rdy    = 1'b0;
    for (int g = 0; g < 64 && !rdy; g++) begin
      @(negedge clk);
      rdy = hready;
      @(posedge clk);
      #1;
    end
    checkBit("complete_in_budget", rdy, 1'b1);
  endtask

  task automatic applyStimulus(input int n_xfers);
    logic [31:0] a;
    int          r;
    requestBus();
    for (int n = 0; n < n_xfers; n++) begin
      r        = $urandom_range(0, 9);
      dbg_addr = AW'($urandom);
      if (r == 0) begin
        htrans = $urandom_range(0, 1) ? TR_BUSY : TR_IDLE;
        haddr  = $urandom;
        hwrite = 1'($urandom);
        hwdata = next_wdata;
        tick();
      end else begin
        if ($urandom_range(0, 1)) a = {$urandom_range(0, 7), 2'b00} + 32'(DEPTH * 4 * $urandom_range(0, 3));
        else a = $urandom;
        addrPhase(a, 1'($urandom), $urandom, r > 5);
      end
    end
    endStream();
    releaseBus();
  endtask

  initial begin
    rst_n = 1'b0; hbusreq = 1'b0; htrans = TR_IDLE; haddr = '0; hwrite = 1'b0;
    hsize = HSIZE_WORD; hburst = HBURST_SINGLE; hwdata = '0; dbg_addr = '0; next_wdata = '0;

    // Reset state, then memory survives a second reset.
    repeat (2) tick();
    checkBit("rst_hready", hready, 1'b1);
    checkBit("rst_hgrant", hgrant, 1'b0);
    checkOutput("rst_hrdata", hrdata, 32'd0);
    rst_n = 1'b1;
    requestBus();
    addrPhase(32'h14, 1'b1, 32'hA5A5A5A5, 1'b0);
    endStream();
    releaseBus();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    checkOutput("rst2_hrdata", hrdata, 32'd0);
    dbg_addr = 10'd5;
    #1;
    checkOutput("preload_dbg5", dbg_rdata, 32'hA5A5A5A5);

    // Grant delay and request withdrawn during the wait.
    hbusreq = 1'b1;
    for (int k = 1; k <= GRANT_DLY; k++) begin
      tick();
      checkBit($sformatf("grant_dly_c%0d", k), hgrant, 1'b0);
    end
    tick();
    checkBit("grant_at_t3", hgrant, 1'b1);
    releaseBus();
    hbusreq = 1'b1;
    tick();
    hbusreq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkBit($sformatf("grant_dropped_c%0d", k), hgrant, 1'b0);
    end

    // Write then back-to-back read of the same word.
    requestBus();
    addrPhase(32'h10, 1'b1, 32'hDEADBEEF, 1'b0);
    addrPhase(32'h10, 1'b0, 32'h0, 1'b1);
    checkOutput("fwd_hrdata", hrdata, 32'hDEADBEEF);
    endStream();
    dbg_addr = 10'd4;
    #1;
    checkOutput("fwd_dbg4", dbg_rdata, 32'hDEADBEEF);

    // INCR4 write then INCR4 read.
    hburst = HBURST_INCR4;
    for (int i = 0; i < 4; i++) addrPhase(32'h100 + 32'(4 * i), 1'b1, 32'(i + 1), i > 0);
    begin
      int c0;
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
        addrPhase(32'h100 + 32'(4 * i), 1'b0, 32'h0, i > 0);
        checkOutput($sformatf("incr4_rd%0d", i), hrdata, 32'(i + 1));
`ifndef AHB_WAIT_STATE_EN
        checkBit($sformatf("incr4_ready%0d", i), hready, 1'b1);
`endif
      end
`ifndef AHB_WAIT_STATE_EN
      checkOutput("incr4_cycles", 32'(cyc - c0), 32'd4);
`endif
    end
    endStream();
    hburst = HBURST_SINGLE;

`ifdef AHB_WAIT_STATE_EN
    // Wait states: HREADY 0,0,1 with stable read data; write lands on HREADY=1.
    addrPhase(32'h104, 1'b0, 32'h0, 1'b0);
    htrans = TR_IDLE;
    for (int k = 0; k < 3; k++) begin
      checkBit($sformatf("ws_hready_c%0d", k), hready, k == 2);
      checkOutput($sformatf("ws_hrdata_c%0d", k), hrdata, 32'd2);
      if (k < 2) tick();
    end
    tick();
    addrPhase(32'h108, 1'b1, 32'h55, 1'b0);
    htrans   = TR_IDLE;
    hwdata   = 32'h66;
    dbg_addr = 10'h42;
    tick();
    tick();
    checkOutput("ws_wr_not_early", dbg_rdata, 32'd3);
    hwdata = 32'h55;
    tick();
    checkOutput("ws_wr_on_ready", dbg_rdata, 32'h55);
`endif

    // Address wrap, then reset in the middle of a write data phase.
    addrPhase(32'h1000 + 32'(4 * DEPTH), 1'b1, 32'hC0FFEE00, 1'b0);
    endStream();
    dbg_addr = 10'd0;
    #1;
    checkOutput("wrap_dbg0", dbg_rdata, 32'hC0FFEE00);
    addrPhase(32'h20, 1'b1, 32'h11111111, 1'b0);
    endStream();
    addrPhase(32'h20, 1'b1, 32'h22222222, 1'b0);
    hwdata  = 32'h22222222;
    htrans  = TR_IDLE;
    hbusreq = 1'b0;
    rst_n   = 1'b0;
    tick();
    checkBit("midrst_hgrant", hgrant, 1'b0);
    dbg_addr = 10'd8;
    #1;
    checkOutput("midrst_dbg8", dbg_rdata, 32'h11111111);
    rst_n = 1'b1;
    tick();

    // Fill every word, then randomized pipelined traffic.
    requestBus();
    for (int i = 0; i < DEPTH; i++) addrPhase(32'(i * 4), 1'b1, $urandom, i > 0);
    endStream();
    releaseBus();
    applyStimulus(600);

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_count, check_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
